// File: rtl/input_controller.sv
// -----------------------------------------------------------------------------
// input_controller
//
// Sequences CPU input requests against the two user-entry sources on the
// board: the PS/2 keyboard decoder (committed value plus Enter flag) and the
// 16-bit switch bank with its confirm push-button. A request stalls the CPU
// until a fresh commit event arrives from the selected source. The captured
// word is then returned together with a one-cycle ack.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a confirm level change
//                    is accepted
//
// Ports:
//   clk         in   system clock, all state on posedge
//   rst         in   asynchronous active-high reset
//   req         in   CPU input request, held until ack is seen
//   src_sel     in   source select sampled on acceptance (0 kb, 1 switches)
//   kb_data     in   [31:0] committed keyboard value
//   kb_temp     in   [31:0] in-progress keyboard value (display only)
//   kb_enter    in   keyboard commit flag, asynchronous level
//   sw_data     in   [15:0] switch bank
//   sw_confirm  in   raw confirm button, asynchronous and bouncing
//   rd_data     out  [31:0] captured input word
//   ack         out  one-cycle pulse, rd_data valid in this cycle
//   stall       out  CPU stall request
//   disp_data   out  [31:0] value for the seven-segment driver
//   state_o     out  [1:0] FSM state code for the status LEDs
// -----------------------------------------------------------------------------
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        src_sel,
  input  logic [31:0] kb_data,
  input  logic [31:0] kb_temp,
  input  logic        kb_enter,
  input  logic [15:0] sw_data,
  input  logic        sw_confirm,
  output logic [31:0] rd_data,
  output logic        ack,
  output logic        stall,
  output logic [31:0] disp_data,
  output logic [1:0]  state_o
);

  // The counter only ever needs to reach DEBOUNCE_CYCLES-1; the cycle that
  // would make it DEBOUNCE_CYCLES flips the level and clears it instead.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_KB = 2'd1,
    WAIT_SW = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [31:0] rd_data_q, rd_data_d;

  logic kb_meta_q, kb_meta_d;
  logic kb_sync_q, kb_sync_d;
  logic kb_prev_q, kb_prev_d;

  logic sw_meta_q, sw_meta_d;
  logic sw_sync_q, sw_sync_d;

  logic             db_level_q, db_level_d;
  logic             db_prev_q, db_prev_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  logic kb_edge;
  logic sw_edge;

  // Synchronizer chains and the delayed copies used for edge detection.
  always_comb begin
    kb_meta_d = kb_enter;
    kb_sync_d = kb_meta_q;
    kb_prev_d = kb_sync_q;
    sw_meta_d = sw_confirm;
    sw_sync_d = sw_meta_q;
    db_prev_d = db_level_q;
  end

  // Only a rising edge counts as a commit, so a level already high when a
  // request arrives never completes it.
  assign kb_edge = kb_sync_q & ~kb_prev_q;
  assign sw_edge = db_level_q & ~db_prev_q;

  // Debouncer: any cycle where the synced button agrees with the accepted
  // level restarts the count, so only an unbroken run of disagreement flips it.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sw_sync_q != db_level_q) begin
      if (db_cnt_q == CNT_MAX) begin
        db_level_d = sw_sync_q;
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic. The chosen source is remembered purely by which wait
  // state we enter, so later src_sel changes are ignored. Edges seen in IDLE
  // or RESP are simply dropped rather than queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = src_sel ? WAIT_SW : WAIT_KB;
        end
      end
      WAIT_KB: begin
        if (!req) begin
          state_d = IDLE;
        end else if (kb_edge) begin
          state_d = RESP;
        end
      end
      WAIT_SW: begin
        if (!req) begin
          state_d = IDLE;
        end else if (sw_edge) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture of the returned word; only the latched source's edge loads it,
  // and an abort leaves the previous value in place.
  always_comb begin
    rd_data_d = rd_data_q;
    if (state_q == WAIT_KB && req && kb_edge) begin
      rd_data_d = kb_data;
    end else if (state_q == WAIT_SW && req && sw_edge) begin
      rd_data_d = {16'b0, sw_data};
    end
  end

  // Output decode. Stall is qualified by rst so the CPU is never held while
  // the controller itself is in reset.
  always_comb begin
    ack       = 1'b0;
    stall     = 1'b0;
    disp_data = rd_data_q;
    unique case (state_q)
      IDLE: begin
        stall = req;
      end
      WAIT_KB: begin
        stall     = 1'b1;
        disp_data = kb_temp;
      end
      WAIT_SW: begin
        stall     = 1'b1;
        disp_data = {16'b0, sw_data};
      end
      RESP: begin
        ack = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    if (rst) begin
      stall = 1'b0;
    end
  end

  assign rd_data = rd_data_q;
  assign state_o = state_q;

  // State register for the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, synchronizer and debouncer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      kb_meta_q  <= 1'b0;
      kb_sync_q  <= 1'b0;
      kb_prev_q  <= 1'b0;
      sw_meta_q  <= 1'b0;
      sw_sync_q  <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      kb_meta_q  <= kb_meta_d;
      kb_sync_q  <= kb_sync_d;
      kb_prev_q  <= kb_prev_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

endmodule

// File: tb/tb_input_controller.sv
// -----------------------------------------------------------------------------
// tb_input_controller
//
// Directed bench for input_controller with DEBOUNCE_CYCLES = 4. Inputs are
// driven on the falling clock edge and outputs are sampled on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_input_controller;

  localparam int DEB = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic        src_sel;
  logic [31:0] kb_data;
  logic [31:0] kb_temp;
  logic        kb_enter;
  logic [15:0] sw_data;
  logic        sw_confirm;
  logic [31:0] rd_data;
  logic        ack;
  logic        stall;
  logic [31:0] disp_data;
  logic [1:0]  state_o;

  int vectors;
  int miscompares;
  int ackSeen;
  int lat;

  input_controller #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .src_sel   (src_sel),
    .kb_data   (kb_data),
    .kb_temp   (kb_temp),
    .kb_enter  (kb_enter),
    .sw_data   (sw_data),
    .sw_confirm(sw_confirm),
    .rd_data   (rd_data),
    .ack       (ack),
    .stall     (stall),
    .disp_data (disp_data),
    .state_o   (state_o)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives the control inputs; data buses are set directly by the sequence.
  task automatic applyStimulus(input logic r, input logic s, input logic ke,
                               input logic sc);
    req        = r;
    src_sel    = s;
    kb_enter   = ke;
    sw_confirm = sc;
  endtask

  // Moves forward n rising edges and parks on the following falling edge.
  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Runs n cycles while counting any ack pulses into ackSeen.
  task automatic runWatch(input int n);
    for (int i = 0; i < n; i++) begin
      advance(1);
      if (ack === 1'b1) ackSeen++;
    end
  endtask

  // Waits up to maxCycles edges for ack; n is the edge count at which ack was
  // seen, or -1 if the bound expired.
  task automatic waitAck(input int maxCycles, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= maxCycles && !found; i++) begin
      advance(1);
      if (ack === 1'b1) begin
        found = 1'b1;
        n = i;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ackSeen     = 0;
    lat         = 0;
    rst         = 1'b1;
    kb_data     = '0;
    kb_temp     = '0;
    sw_data     = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held with req high.
    advance(3);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_rd", rd_data, 32'd0);
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_disp", disp_data, 32'd0);

    rst = 1'b0;
    #1;
    checkOutput("rel_stall", 32'(stall), 32'd1);
    checkOutput("rel_state", 32'(state_o), 32'd0);
    advance(1);
    checkOutput("acc_state", 32'(state_o), 32'd1);
    checkOutput("acc_stall", 32'(stall), 32'd1);

    // Keyboard read; display follows kb_temp while waiting.
    kb_temp = 32'h0000_00BE;
    #1;
    checkOutput("kb_disp1", disp_data, 32'h0000_00BE);
    kb_temp = 32'h0000_0BEE;
    #1;
    checkOutput("kb_disp2", disp_data, 32'h0000_0BEE);
    kb_data = 32'h0000_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitAck(10, lat);
    checkOutput("kb_lat", 32'(lat), 32'd3);
    checkOutput("kb_rd", rd_data, 32'h0000_BEEF);
    checkOutput("kb_ack_stall", 32'(stall), 32'd0);
    checkOutput("kb_ack_state", 32'(state_o), 32'd3);
    checkOutput("kb_ack_disp", disp_data, 32'h0000_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    advance(1);
    checkOutput("kb_ack_once", 32'(ack), 32'd0);
    checkOutput("kb_idle_state", 32'(state_o), 32'd0);
    checkOutput("kb_idle_stall", 32'(stall), 32'd0);

    // Stale Enter level must not complete a new request.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    advance(1);
    checkOutput("stale_state", 32'(state_o), 32'd1);
    ackSeen = 0;
    runWatch(6);
    checkOutput("stale_noack", 32'(ackSeen), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    advance(3);
    kb_data = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitAck(10, lat);
    checkOutput("stale_lat", 32'(lat), 32'd3);
    checkOutput("stale_rd", rd_data, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    advance(1);

    // Switch read through a bouncing confirm button.
    sw_data = 16'hA5C3;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    advance(1);
    checkOutput("sw_state", 32'(state_o), 32'd2);
    checkOutput("sw_disp", disp_data, 32'h0000_A5C3);
    ackSeen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      runWatch(2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      runWatch(2);
    end
    checkOutput("sw_bounce_noack", 32'(ackSeen), 32'd0);
    checkOutput("sw_bounce_state", 32'(state_o), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    waitAck(20, lat);
    checkOutput("sw_lat", 32'(lat), 32'(DEB + 3));
    checkOutput("sw_rd", rd_data, 32'h0000_A5C3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    ackSeen = 0;
    runWatch(3);
    checkOutput("sw_single_ack", 32'(ackSeen), 32'd0);

    // Keyboard edge while waiting on switches, then abort.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    advance(1);
    checkOutput("ws_state", 32'(state_o), 32'd2);
    ackSeen = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    runWatch(3);
    kb_data = 32'hDEAD_0000;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    runWatch(5);
    checkOutput("ws_noack", 32'(ackSeen), 32'd0);
    checkOutput("ws_still_wait", 32'(state_o), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    advance(1);
    checkOutput("ab_state", 32'(state_o), 32'd0);
    checkOutput("ab_stall", 32'(stall), 32'd0);
    checkOutput("ab_rd", rd_data, 32'h0000_A5C3);

    // Reset while waiting on the keyboard.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    advance(1);
    checkOutput("rm_wait", 32'(state_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rm_state", 32'(state_o), 32'd0);
    checkOutput("rm_rd", rd_data, 32'd0);
    checkOutput("rm_stall", 32'(stall), 32'd0);
    checkOutput("rm_ack", 32'(ack), 32'd0);
    advance(2);
    rst = 1'b0;
    #1;
    checkOutput("rm_rel_stall", 32'(stall), 32'd1);
    advance(1);
    checkOutput("rm_rel_state", 32'(state_o), 32'd1);

    // Back-to-back keyboard reads with req held high throughout.
    kb_data = 32'hCAFE_0001;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitAck(10, lat);
    checkOutput("bb1_lat", 32'(lat), 32'd3);
    checkOutput("bb1_rd", rd_data, 32'hCAFE_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    advance(1);
    checkOutput("bb_idle_state", 32'(state_o), 32'd0);
    checkOutput("bb_idle_stall", 32'(stall), 32'd1);
    advance(1);
    checkOutput("bb_rewait", 32'(state_o), 32'd1);
    kb_data = 32'hCAFE_0002;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitAck(10, lat);
    checkOutput("bb2_lat", 32'(lat), 32'd3);
    checkOutput("bb2_rd", rd_data, 32'hCAFE_0002);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    advance(1);
    checkOutput("bb_end_state", 32'(state_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
